// File: rtl/tach_freq_meter.sv
// Fan tachometer frequency meter: synchronizes and deglitches tach_in, then
// counts filtered rising edges over back-to-back gate windows of GATE_CYCLES clocks.
module tach_freq_meter #(
  parameter int GATE_CYCLES = 100000000,
  parameter int CNT_W       = 16,
  parameter int FILT        = 4
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             enable,
  input  logic             tach_in,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             overflow,
  output logic             stalled
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int FW = $clog2(FILT + 1);
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [FW-1:0]    FILT_LAST = FW'(FILT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {IDLE, COUNT} state_t;

  logic [1:0]       sync_q;
  logic             filt_q, filt_d, filt_prev_q;
  logic [FW-1:0]    fcnt_q, fcnt_d;
  logic             edge_pulse;

  state_t           state_q, state_d;
  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] ecnt_q, ecnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             ovf_q, ovf_d;
  logic             stall_q, stall_d;
  logic             valid_q, valid_d;
  logic             at_max, inc;

  // Synchronizer and filter free-run so a level already high at enable rise is not an edge.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync_q[1] != filt_q) begin
      if (fcnt_q == FILT_LAST) filt_d = sync_q[1];
      else                     fcnt_d = fcnt_q + FW'(1);
    end
  end

  assign edge_pulse = filt_q & ~filt_prev_q;
  assign at_max     = (ecnt_q == CNT_MAX);
  assign inc        = edge_pulse & ~at_max;

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    ecnt_d  = ecnt_q;
    sat_d   = sat_q;
    freq_d  = freq_q;
    ovf_d   = ovf_q;
    stall_d = stall_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        gate_d = '0;
        ecnt_d = '0;
        sat_d  = 1'b0;
        if (enable) state_d = COUNT;
      end
      COUNT: begin
        if (!enable) begin
          // Partial window is dropped, including on the final gate cycle.
          state_d = IDLE;
          gate_d  = '0;
          ecnt_d  = '0;
          sat_d   = 1'b0;
        end else if (gate_q == GATE_LAST) begin
          freq_d  = ecnt_q + CNT_W'(inc);
          ovf_d   = sat_q | (edge_pulse & at_max);
          stall_d = (ecnt_q == '0) & ~edge_pulse;
          valid_d = 1'b1;
          gate_d  = '0;
          ecnt_d  = '0;
          sat_d   = 1'b0;
        end else begin
          gate_d = gate_q + GW'(1);
          ecnt_d = ecnt_q + CNT_W'(inc);
          sat_d  = sat_q | (edge_pulse & at_max);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      sync_q      <= '0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      fcnt_q      <= '0;
      state_q     <= IDLE;
      gate_q      <= '0;
      ecnt_q      <= '0;
      sat_q       <= 1'b0;
      freq_q      <= '0;
      ovf_q       <= 1'b0;
      stall_q     <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], tach_in};
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      gate_q      <= gate_d;
      ecnt_q      <= ecnt_d;
      sat_q       <= sat_d;
      freq_q      <= freq_d;
      ovf_q       <= ovf_d;
      stall_q     <= stall_d;
      valid_q     <= valid_d;
    end
  end

  assign freq       = freq_q;
  assign freq_valid = valid_q;
  assign overflow   = ovf_q;
  assign stalled    = stall_q;

endmodule
